// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO. Everything runs on wr_clk_i. Drives the storage
// write port, publishes the Gray write pointer to the read domain, and derives full,
// almost-full and occupancy from a two-flop synchronised copy of the read Gray pointer.
module fifo_wr_ctrl #(
  parameter int unsigned DLY        = 1,
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic                  wr_clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [FIFO_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [FIFO_WIDTH-1:0] mem_data_o,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_cnt_o,
  output logic                  wr_ack_o,
  output logic                  overflow_o
);

  localparam int unsigned PtrW  = ADDR_WIDTH + 1;
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AfThresh = PtrW'(Depth - AF_MARGIN);

  // Register update delay is a simulation-only notion; it has no effect on this RTL.
  logic [31:0] unused_dly;
  assign unused_dly = DLY;

  logic [ADDR_WIDTH:0] wr_bin_q, wr_bin_d;
  logic [ADDR_WIDTH:0] wr_gray_q, wr_gray_d;
  logic [ADDR_WIDTH:0] rq1_q, rq2_q;
  logic [ADDR_WIDTH:0] rd_bin_sync;
  logic [ADDR_WIDTH:0] occ_d;
  logic [ADDR_WIDTH:0] full_gray;
  logic                full_q, full_d;
  logic                af_q, af_d;
  logic [ADDR_WIDTH:0] cnt_q;
  logic                ack_q, ack_d;
  logic                ovf_q, ovf_d;
  logic                accept;

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all bits at or above i.
  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i < int'(PtrW); i++) begin
      rd_bin_sync[i] = ^(rq2_q >> i);
    end
  end

  // Acceptance, storage port and next-state for pointers and flags.
  always_comb begin
    // Only the registered full flag gates writes; reset blocks the storage write port.
    accept    = wr_en_i & ~full_q & ~rst_i;
    wr_bin_d  = wr_bin_q + PtrW'(accept);
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    occ_d     = wr_bin_d - rd_bin_sync;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_gray = {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1], rq2_q[ADDR_WIDTH-2:0]};
    full_d    = (wr_gray_d == full_gray);
    af_d      = (occ_d >= AfThresh);
    ack_d     = accept;
    ovf_d     = wr_en_i & full_q;
  end

  // Pointer, synchroniser and registered-flag state; synchronous reset wins over everything.
  always_ff @(posedge wr_clk_i) begin
    if (rst_i) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      rq1_q     <= '0;
      rq2_q     <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      rq1_q     <= rd_ptr_gray_i;
      rq2_q     <= rq1_q;
      full_q    <= full_d;
      af_q      <= af_d;
      cnt_q     <= occ_d;
      ack_q     <= ack_d;
      ovf_q     <= ovf_d;
    end
  end

  assign mem_we_o      = accept;
  assign mem_addr_o    = wr_bin_q[ADDR_WIDTH-1:0];
  assign mem_data_o    = wr_data_i;
  assign wr_ptr_gray_o = wr_gray_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign wr_cnt_o      = cnt_q;
  assign wr_ack_o      = ack_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: stimulus pushes expected per-cycle outputs into a queue, a monitor on
// the falling edge pops and compares; directed checks cover reset, fill, overflow, release, wrap.
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [4:0] rd_gray;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic [4:0] wr_gray;
  logic       full;
  logic       af;
  logic [4:0] cnt;
  logic       ack;
  logic       ovf;

  fifo_wr_ctrl #(
    .DLY       (1),
    .FIFO_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_MARGIN (2)
  ) dut (
    .wr_clk_i     (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .rd_ptr_gray_i(rd_gray),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .wr_ptr_gray_o(wr_gray),
    .full_o       (full),
    .almost_full_o(af),
    .wr_cnt_o     (cnt),
    .wr_ack_o     (ack),
    .overflow_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       chk_regs;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] cnt;
    logic       ack;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: binary write count and binary read count delayed through two stages.
  int   m_wr, m_rq1, m_rq2, m_cnt;
  logic m_full, m_af, m_ack, m_ovf, m_valid;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show during this cycle.
  task automatic apply(input logic en, input logic [7:0] d, input int rdbin, input logic r);
    exp_t e;
    logic acc;
    int   nw, occ;
    wr_en   = en;
    wr_data = d;
    rd_gray = gray5(rdbin);
    rst     = r;
    acc        = en & ~r & (m_valid ? ~m_full : 1'b1);
    e.chk_regs = m_valid;
    e.we       = acc;
    e.addr     = 4'(m_wr % 16);
    e.data     = d;
    e.gray     = gray5(m_wr);
    e.full     = m_full;
    e.af       = m_af;
    e.cnt      = 5'(m_cnt);
    e.ack      = m_ack;
    e.ovf      = m_ovf;
    exp_q.push_back(e);
    if (r) begin
      m_wr = 0; m_rq1 = 0; m_rq2 = 0; m_cnt = 0;
      m_full = 0; m_af = 0; m_ack = 0; m_ovf = 0;
      m_valid = 1;
    end else begin
      nw     = (m_wr + int'(acc)) % 32;
      occ    = (nw - m_rq2 + 32) % 32;
      m_ovf  = en & m_full;
      m_full = (occ == 16);
      m_af   = (occ >= 14);
      m_cnt  = occ;
      m_ack  = acc;
      m_rq2  = m_rq1;
      m_rq1  = rdbin % 32;
      m_wr   = nw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents its outputs every cycle; compare them mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) begin
          cmp("mem_addr", 32'(mem_addr), 32'(e.addr));
          cmp("mem_data", 32'(mem_data), 32'(e.data));
        end
        if (e.chk_regs) begin
          cmp("wr_ptr_gray", 32'(wr_gray), 32'(e.gray));
          cmp("full", 32'(full), 32'(e.full));
          cmp("almost_full", 32'(af), 32'(e.af));
          cmp("wr_cnt", 32'(cnt), 32'(e.cnt));
          cmp("wr_ack", 32'(ack), 32'(e.ack));
          cmp("overflow", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    int         acks;
    int         wptr;
    logic [4:0] prev;
    logic       seen_wrap;
    m_wr = 0; m_rq1 = 0; m_rq2 = 0; m_cnt = 0;
    m_full = 0; m_af = 0; m_ack = 0; m_ovf = 0; m_valid = 0;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_gray = '0;
    tick();

    // Reset with write requested: storage port stays quiet, outputs clear.
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 8'h55, 0, 1'b1);
      #2 cmp("reset_mem_we", 32'(mem_we), 32'd0);
      tick();
    end
    cmp("reset_gray", 32'(wr_gray), 32'd0);
    cmp("reset_full", 32'(full), 32'd0);
    cmp("reset_cnt", 32'(cnt), 32'd0);
    cmp("reset_ack", 32'(ack), 32'd0);

    // Fill with 16 back-to-back writes.
    acks = 0;
    for (int k = 1; k <= 16; k++) begin
      apply(1'b1, 8'(8'hA0 + k), 0, 1'b0);
      tick();
      if (ack) acks++;
      if (k == 13) cmp("af_before_14", 32'(af), 32'd0);
      if (k == 14) begin
        cmp("af_at_14", 32'(af), 32'd1);
        cmp("cnt_at_14", 32'(cnt), 32'd14);
      end
      if (k == 15) cmp("full_before_16", 32'(full), 32'd0);
    end
    cmp("full_at_16", 32'(full), 32'd1);
    cmp("cnt_at_16", 32'(cnt), 32'd16);
    cmp("gray_at_16", 32'(wr_gray), 32'b11000);
    cmp("ack_cycles", 32'(acks), 32'd16);

    // Overflow: 17th write dropped.
    apply(1'b1, 8'hEE, 0, 1'b0);
    #2 cmp("ovf_mem_we", 32'(mem_we), 32'd0);
    tick();
    cmp("ovf_pulse", 32'(ovf), 32'd1);
    cmp("ovf_no_ack", 32'(ack), 32'd0);
    cmp("ovf_gray_held", 32'(wr_gray), 32'b11000);
    apply(1'b0, 8'h00, 0, 1'b0);
    tick();
    cmp("ovf_one_cycle", 32'(ovf), 32'd0);

    // Release: read pointer advances by one; full drops after the third edge.
    for (int e = 1; e <= 3; e++) begin
      apply(1'b0, 8'h00, 1, 1'b0);
      tick();
      if (e < 3) cmp("release_full_held", 32'(full), 32'd1);
    end
    cmp("release_full", 32'(full), 32'd0);
    cmp("release_cnt", 32'(cnt), 32'd15);
    apply(1'b1, 8'h3C, 1, 1'b0);
    #2 cmp("release_we", 32'(mem_we), 32'd1);
    cmp("release_addr", 32'(mem_addr), 32'd0);
    tick();

    // Wrap: pull the read pointer close, then 40 writes with read = write - 4.
    wptr = 17;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 8'h00, wptr - 4, 1'b0);
      tick();
    end
    seen_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev = wr_gray;
      apply(1'b1, 8'(i), (wptr - 4 + 32) % 32, 1'b0);
      tick();
      wptr = (wptr + 1) % 32;
      cmp("wrap_one_bit", 32'($countones(prev ^ wr_gray)), 32'd1);
      cmp("wrap_no_full", 32'(full), 32'd0);
      if (prev == 5'b10000) begin
        cmp("wrap_gray_zero", 32'(wr_gray), 32'd0);
        seen_wrap = 1'b1;
      end
    end
    cmp("wrap_seen", 32'(seen_wrap), 32'd1);

    // Mid-burst reset after 9 writes.
    apply(1'b0, 8'h00, 0, 1'b1);
    tick();
    for (int k = 0; k < 9; k++) begin
      apply(1'b1, 8'(8'h70 + k), 0, 1'b0);
      tick();
    end
    cmp("burst_cnt", 32'(cnt), 32'd9);
    apply(1'b1, 8'h99, 0, 1'b1);
    #2 cmp("midrst_we", 32'(mem_we), 32'd0);
    tick();
    cmp("midrst_gray", 32'(wr_gray), 32'd0);
    cmp("midrst_cnt", 32'(cnt), 32'd0);
    cmp("midrst_full", 32'(full), 32'd0);
    apply(1'b1, 8'h42, 0, 1'b0);
    #2 cmp("post_rst_we", 32'(mem_we), 32'd1);
    cmp("post_rst_addr", 32'(mem_addr), 32'd0);
    tick();
    apply(1'b0, 8'h00, 0, 1'b0);
    tick();

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #6;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
